// File: rtl/instruction_prefetch_buffer.sv
// rtl/instruction_prefetch_buffer.sv - sequential instruction prefetcher with credit-limited FIFO; optional PREFETCH_BYPASS_EN
module instruction_prefetch_buffer #(
    parameter int                      DATA_WIDTH   = 32,
    parameter int                      ADDRESS_BITS = 32,
    parameter int                      DEPTH        = 4,
    parameter logic [ADDRESS_BITS-1:0] RESET_PC     = '0
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    redirect,
    input  logic [ADDRESS_BITS-1:0] redirect_pc,
    output logic                    fetch_valid,
    output logic [DATA_WIDTH-1:0]   fetch_instruction,
    output logic [ADDRESS_BITS-1:0] fetch_pc,
    input  logic                    fetch_ready,
    output logic                    i_mem_read,
    output logic [ADDRESS_BITS-1:0] i_mem_address_in,
    input  logic [DATA_WIDTH-1:0]   i_mem_data_out,
    input  logic [ADDRESS_BITS-1:0] i_mem_address_out,
    input  logic                    i_mem_valid,
    input  logic                    i_mem_ready
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [ADDRESS_BITS-1:0] PC_STEP = ADDRESS_BITS'(DATA_WIDTH / 8);
    localparam logic [CNT_W:0] DEPTH_W = (CNT_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [DATA_WIDTH-1:0]   entry_data [DEPTH];
    logic [ADDRESS_BITS-1:0] entry_pc   [DEPTH];
    logic [PTR_W-1:0]        head;
    logic [PTR_W-1:0]        tail;
    logic [CNT_W-1:0]        count;

    logic [ADDRESS_BITS-1:0] next_pc;
    logic [ADDRESS_BITS-1:0] pending_addr;
    logic                    pending;

    logic                    fifo_empty;
    logic [CNT_W:0]          occupancy;
    logic                    credit_ok;
    logic                    accept;
    logic                    bypass_take;
    logic                    bypass_consumed;
    logic                    push;
    logic                    pop;

    // The in-flight request reserves a slot so a returning response can always be stored
    assign fifo_empty      = (count == '0);
    assign occupancy       = {1'b0, count} + {{CNT_W{1'b0}}, pending};
    assign credit_ok       = (occupancy < DEPTH_W);
    assign accept          = i_mem_valid && pending && (i_mem_address_out == pending_addr);

`ifdef PREFETCH_BYPASS_EN
    assign bypass_take     = fifo_empty && accept;
`else
    assign bypass_take     = 1'b0;
`endif
    assign bypass_consumed = bypass_take && fetch_ready;

    // A redirect discards both the queued entries and whatever arrives in the same cycle
    assign push            = accept && !bypass_consumed && !redirect;
    assign pop             = !fifo_empty && fetch_ready && !redirect;

    assign i_mem_address_in = next_pc;

    // Head presentation: FIFO head, or the live response when bypassing an empty FIFO
    always_comb begin
        fetch_valid       = !fifo_empty;
        fetch_instruction = fifo_empty ? '0 : entry_data[head];
        fetch_pc          = fifo_empty ? '0 : entry_pc[head];
        if (bypass_take) begin
            fetch_valid       = 1'b1;
            fetch_instruction = i_mem_data_out;
            fetch_pc          = i_mem_address_out;
        end
    end

    // Control state register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_BOOT;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and request issue; requests only flow in RUN
    always_comb begin
        state_next = state;
        i_mem_read = 1'b0;
        case (state)
            S_BOOT: begin
                state_next = S_RUN;
            end
            S_RUN: begin
                i_mem_read = i_mem_ready && !redirect && credit_ok && !reset;
            end
            S_FLUSH: begin
                state_next = S_RUN;
            end
            default: begin
                state_next = S_BOOT;
            end
        endcase
        if (redirect) begin
            state_next = S_FLUSH;
        end
    end

    // Fetch address, outstanding-request tracking and FIFO pointers
    always_ff @(posedge clock) begin
        if (reset) begin
            next_pc      <= RESET_PC;
            pending      <= 1'b0;
            pending_addr <= '0;
            head         <= '0;
            tail         <= '0;
            count        <= '0;
        end else if (redirect) begin
            next_pc      <= redirect_pc;
            pending      <= 1'b0;
            head         <= '0;
            tail         <= '0;
            count        <= '0;
        end else begin
            if (i_mem_read) begin
                pending      <= 1'b1;
                pending_addr <= next_pc;
                next_pc      <= next_pc + PC_STEP;
            end else if (i_mem_valid) begin
                pending      <= 1'b0;
            end
            if (push) begin
                tail <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage; contents are only observable while counted as valid
    always_ff @(posedge clock) begin
        if (push && !reset) begin
            entry_data[tail] <= i_mem_data_out;
            entry_pc[tail]   <= i_mem_address_out;
        end
    end

endmodule

// File: doc/instruction_prefetch_buffer.md
Name: instruction_prefetch_buffer

Overview:
- Sits between the core fetch stage and the instruction port of the dual-port BRAM memory subsystem.
- Drives sequential instruction reads and captures the responses (one-cycle memory latency) into a small FIFO.
- Presents instructions to the core with a valid/ready handshake.
- Handles PC redirects by flushing queued entries and discarding in-flight responses.

Parameters:
- DATA_WIDTH, 32, instruction/memory word width in bits; PC step is DATA_WIDTH/8.
- ADDRESS_BITS, 32, byte address width.
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- RESET_PC, 0, first fetch address after reset.

Ports:
- clock  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-high
- redirect  input  1  core requests a fetch restart
- redirect_pc  input  ADDRESS_BITS  new fetch address, sampled when redirect=1
- fetch_valid  output  1  head entry valid
- fetch_instruction  output  DATA_WIDTH  head instruction
- fetch_pc  output  ADDRESS_BITS  byte address of head instruction
- fetch_ready  input  1  core consumes head when fetch_valid&fetch_ready
- i_mem_read  output  1  read request to memory
- i_mem_address_in  output  ADDRESS_BITS  read address
- i_mem_data_out  input  DATA_WIDTH  read data, one cycle after request
- i_mem_address_out  input  ADDRESS_BITS  address echoed with data
- i_mem_valid  input  1  response valid
- i_mem_ready  input  1  memory can accept a request

Behaviour:
- Clock/reset: one clock. Reset is synchronous and active-high.
- Reset values:
  - FIFO empty; count=0; fetch_valid=0; fetch_instruction=0; fetch_pc=0.
  - next_pc=RESET_PC; pending=0; i_mem_read=0; state=BOOT.
- FSM:
  - BOOT: one cycle, no request issued; then RUN.
  - RUN: normal operation.
  - FLUSH: entered on redirect from RUN. Lasts one cycle, no request issued, then RUN.
  - Redirect in BOOT or FLUSH loads next_pc and stays or returns per the same rules (a FLUSH cycle always follows).
- Issue:
  - In RUN, i_mem_read=1 iff i_mem_ready && !redirect && (count + pending) < DEPTH.
  - i_mem_address_in=next_pc.
  - On issue: pending<=1, pending_addr<=next_pc, next_pc<=next_pc+DATA_WIDTH/8. The increment wraps modulo 2^ADDRESS_BITS.
- Response:
  - Accepted iff i_mem_valid && pending && i_mem_address_out==pending_addr.
  - On acceptance, {data, addr} is pushed to the FIFO tail.
  - pending clears on any i_mem_valid when no new issue is made that cycle.
  - A response with pending=0 or an address mismatch is dropped silently.
- Credit rule: credits guarantee a push never targets a full FIFO. Throughput is one instruction per cycle in steady state.
- Pop: on fetch_valid && fetch_ready, the head advances.
- Simultaneous push and pop: count unchanged. A push into an empty FIFO is visible on fetch_valid the next cycle, so issue-to-fetch_valid latency is 2.
- Redirect (any state), next edge:
  - FIFO flushed (count=0, fetch_valid=0); pending=0, so the in-flight response is discarded.
  - next_pc<=redirect_pc; state<=FLUSH.
  - A pop in the redirect cycle is ignored.
- Full: count==DEPTH gives no issue and fetch_valid=1. Empty: fetch_valid=0.
- Reset mid-operation: all state returns to reset values; in-flight responses are discarded because pending=0.

Optional Feature:
- Macro: PREFETCH_BYPASS_EN.
- Defined:
  - When the FIFO is empty and a response is accepted, fetch_valid/fetch_instruction/fetch_pc are driven combinationally from the memory response in the same cycle.
  - If fetch_ready=1 that cycle, the entry is not pushed. Otherwise it is pushed normally.
  - Issue-to-fetch_valid latency becomes 1.
- Undefined: all responses go through the FIFO; latency is 2.

Test Plan:
- Boot stream: reset 2 cycles, RESET_PC=0x100, fetch_ready=1 → i_mem_read first high in cycle 2 after reset. fetch_pc sequence 0x100,0x104,0x108… at one per cycle; first fetch_valid 2 cycles after first issue (1 with PREFETCH_BYPASS_EN).
- Backpressure: fetch_ready=0 for 10 cycles, DEPTH=4 → exactly 4 requests issued, then i_mem_read=0 and count=4. Releasing fetch_ready drains 0x100..0x10C in order, no loss or duplicate.
- Redirect with in-flight read: redirect=1 and redirect_pc=0x2000 in a cycle with pending=1 → returning response dropped, fetch_valid=0 next cycle, one FLUSH cycle. Next fetch_pc seen is 0x2000.
- Memory stall: i_mem_ready=0 for 5 cycles mid-stream → no requests during the stall. Stream resumes at the correct next_pc with no gaps.
- Wrap-around: ADDRESS_BITS=8, redirect_pc=0xF8 → fetch_pc sequence 0xF8,0xFC,0x00,0x04.
- Reset mid-stream: assert reset with FIFO holding 3 entries and pending=1 → next cycle fetch_valid=0, i_mem_read=0. Restart from RESET_PC.
